onehot_to_binary_stream: RTL and testbench

- Pipelined one-hot to binary decoder with valid/ready handshaking on both sides, mapping a ONE_HOT_W-bit one-hot word to its BIN_W-bit index.
- Flags every malformed input: an all-zero word or a word with more than one bit set.
- Sits downstream of the binary-to-one-hot converter in arbitration and select datapaths, where it recovers the index from grant/select vectors.
- Also serves as the round-trip check partner for that converter in the block-level bench.

---
 rtl/onehot_to_binary_stream.sv | 114 +++++++++++
 tb/tb_onehot_to_binary_stream.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_to_binary_stream.sv
// Two-stage valid/ready one-hot to binary decoder that flags all-zero and multi-hot words.
// Define ONEHOT_TO_BINARY_STREAM_ERR_CNT_EN to build the saturating malformed-word counter.
module onehot_to_binary_stream #(
  parameter int ONE_HOT_W = 16,
  parameter int BIN_W     = $clog2(ONE_HOT_W)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 err_zero_o,
  output logic                 err_multi_o,
  output logic [15:0]          err_cnt_o
);

  localparam int CNT_W = $clog2(ONE_HOT_W + 1);

  logic                 s1_valid;
  logic [ONE_HOT_W-1:0] s1_word;
  logic                 s1_zero;
  logic                 s1_multi;

  logic                 s2_valid;
  logic [BIN_W-1:0]     s2_bin;
  logic                 s2_zero;
  logic                 s2_multi;

  logic                 s2_load;
  logic                 out_fire;
  logic [CNT_W-1:0]     pop_cnt;
  logic [BIN_W-1:0]     enc_bin;

  assign out_fire = s2_valid && ready_i;
  assign s2_load  = !s2_valid || ready_i;
  assign ready_o  = !s1_valid || s2_load;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < ONE_HOT_W; i++) begin
      pop_cnt = pop_cnt + CNT_W'(one_hot_i[i]);
    end
  end

  // Scan from the top down so the lowest set bit wins; a zero word encodes to 0.
  always_comb begin
    enc_bin = '0;
    for (int i = ONE_HOT_W - 1; i >= 0; i--) begin
      if (s1_word[i]) begin
        enc_bin = BIN_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_zero  <= 1'b0;
      s1_multi <= 1'b0;
    end else if (ready_o) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_word  <= one_hot_i;
        s1_zero  <= (pop_cnt == '0);
        s1_multi <= (pop_cnt >= CNT_W'(2));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_bin   <= '0;
      s2_zero  <= 1'b0;
      s2_multi <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_bin   <= enc_bin;
        s2_zero  <= s1_zero;
        s2_multi <= s1_multi;
      end
    end
  end

  assign valid_o     = s2_valid;
  assign bin_o       = s2_bin;
  assign err_zero_o  = s2_zero;
  assign err_multi_o = s2_multi;

`ifdef ONEHOT_TO_BINARY_STREAM_ERR_CNT_EN
  logic [15:0] err_cnt;

  // Counts errored words as they leave, holding at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt <= '0;
    end else if (out_fire && (s2_zero || s2_multi) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt;
`else
  logic unused_fire;
  assign unused_fire = out_fire;
  assign err_cnt_o   = 16'h0000;
`endif

endmodule

// File: tb/tb_onehot_to_binary_stream.sv
// Directed self-checking bench for onehot_to_binary_stream (honours ONEHOT_TO_BINARY_STREAM_ERR_CNT_EN).
module tb_onehot_to_binary_stream;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [15:0] one_hot_i;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  bin_o;
  logic        err_zero_o;
  logic        err_multi_o;
  logic [15:0] err_cnt_o;

  int checks = 0;
  int errors = 0;

  onehot_to_binary_stream #(.ONE_HOT_W(16), .BIN_W(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .one_hot_i   (one_hot_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .bin_o       (bin_o),
    .err_zero_o  (err_zero_o),
    .err_multi_o (err_multi_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive inputs and let combinational outputs settle before any check.
  task automatic apply_stimulus(input logic v, input logic [15:0] w, input logic r);
    valid_i   = v;
    one_hot_i = w;
    ready_i   = r;
    #1;
  endtask

  task automatic check_word(input string tag, input logic v, input logic [3:0] b, input logic z, input logic m);
    check_output({tag, "_valid"}, 32'(valid_o), 32'(v));
    check_output({tag, "_bin"},   32'(bin_o), 32'(b));
    check_output({tag, "_zero"},  32'(err_zero_o), 32'(z));
    check_output({tag, "_multi"}, 32'(err_multi_o), 32'(m));
  endtask

  function automatic logic [15:0] cnt_exp(input logic [15:0] v);
`ifdef ONEHOT_TO_BINARY_STREAM_ERR_CNT_EN
    return v;
`else
    return (v == v) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  initial begin
    // Reset
    rst_i = 1'b1;
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check_word("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    check_output("reset_cnt", 32'(err_cnt_o), 32'h0);
    check_output("reset_ready", 32'(ready_o), 32'h1);

    // Full sweep: word i appears two ticks after it is driven
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        apply_stimulus(1'b1, 16'(1) << i, 1'b1);
        check_output("sweep_ready", 32'(ready_o), 32'h1);
      end else begin
        apply_stimulus(1'b0, 16'h0000, 1'b1);
      end
      tick();
      if (i == 0) check_output("sweep_first_valid", 32'(valid_o), 32'h0);
      else        check_word("sweep", 1'b1, 4'(i - 1), 1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    tick();
    check_output("sweep_drained", 32'(valid_o), 32'h0);
    check_output("sweep_cnt", 32'(err_cnt_o), 32'(cnt_exp(16'd0)));

    // Malformed inputs
    apply_stimulus(1'b1, 16'h0000, 1'b1);
    tick();
    apply_stimulus(1'b1, 16'h0030, 1'b1);
    tick();
    check_word("zero_word", 1'b1, 4'd0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    tick();
    check_word("multi_word", 1'b1, 4'd4, 1'b0, 1'b1);
    check_output("malformed_cnt1", 32'(err_cnt_o), 32'(cnt_exp(16'd1)));
    tick();
    check_output("malformed_drained", 32'(valid_o), 32'h0);
    check_output("malformed_cnt2", 32'(err_cnt_o), 32'(cnt_exp(16'd2)));

    // Back-pressure: only two words fit while ready_i is low
    apply_stimulus(1'b1, 16'h0100, 1'b0);
    check_output("bp_ready_a", 32'(ready_o), 32'h1);
    tick();
    apply_stimulus(1'b1, 16'h0004, 1'b0);
    check_output("bp_ready_b", 32'(ready_o), 32'h1);
    tick();
    check_word("bp_hold0", 1'b1, 4'd8, 1'b0, 1'b0);
    apply_stimulus(1'b1, 16'h8000, 1'b0);
    check_output("bp_ready_full", 32'(ready_o), 32'h0);
    tick();
    check_word("bp_hold1", 1'b1, 4'd8, 1'b0, 1'b0);
    check_output("bp_still_full", 32'(ready_o), 32'h0);
    tick();
    check_word("bp_hold2", 1'b1, 4'd8, 1'b0, 1'b0);
    apply_stimulus(1'b1, 16'h8000, 1'b1);
    check_output("bp_ready_release", 32'(ready_o), 32'h1);
    tick();
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_word("bp_out_b", 1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    check_word("bp_out_c", 1'b1, 4'd15, 1'b0, 1'b0);
    tick();
    check_output("bp_drained", 32'(valid_o), 32'h0);

    // Mid-stream reset discards two words in flight
    apply_stimulus(1'b1, 16'h0002, 1'b0);
    tick();
    apply_stimulus(1'b1, 16'h0000, 1'b0);
    tick();
    check_word("pre_reset", 1'b1, 4'd1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 16'h0000, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check_word("mid_reset", 1'b0, 4'd0, 1'b0, 1'b0);
    check_output("mid_reset_cnt", 32'(err_cnt_o), 32'h0);
    check_output("mid_reset_ready", 32'(ready_o), 32'h1);
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("post_reset_valid", 32'(valid_o), 32'h0);
    end

    // Counter saturation, or counter stays zero without the macro
`ifdef ONEHOT_TO_BINARY_STREAM_ERR_CNT_EN
    force dut.err_cnt = 16'hFFFE;
    #1;
    release dut.err_cnt;
    #1;
    check_output("sat_preload", 32'(err_cnt_o), 32'hFFFE);
`endif
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 16'h0000, 1'b1);
      tick();
    end
    apply_stimulus(1'b0, 16'h0000, 1'b1);
    check_word("sat_word", 1'b1, 4'd0, 1'b1, 1'b0);
    tick();
    check_output("sat_cnt_a", 32'(err_cnt_o), 32'(cnt_exp(16'hFFFF)));
    tick();
    check_output("sat_cnt_b", 32'(err_cnt_o), 32'(cnt_exp(16'hFFFF)));
    tick();
    check_output("sat_drained", 32'(valid_o), 32'h0);
    check_output("sat_cnt_c", 32'(err_cnt_o), 32'(cnt_exp(16'hFFFF)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
